tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
//
// Round-robin arbiter that accepts 32-bit words from NUM_REQ requesters and
// serializes each one, most-significant byte first, into a byte-wide UART
// transmitter. Each byte goes through a start / busy-acknowledge / busy-done
// handshake before the next byte is started.
//
// Optional feature (compile-time macro):
//   TX_ARBITER_HEADER_EN  -- each word is preceded by a header byte
//                            {5'b10100, grant_id}, giving 5 bytes per word.
//                            Undefined (default): 4 data bytes per word and no
//                            header logic.
//
// Parameters:
//   NUM_REQ    number of requesters, 2..8
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  [NUM_REQ]     requester i presents a word
//   req_data   [32*NUM_REQ]  word of requester i at bits [32i+31:32i]
//   req_ready  [NUM_REQ]     one-cycle accept pulse for requester i
//   tx_busy    UART transmitter busy flag
//   tx_start   one-cycle pulse asking the UART to send tx_data
//   tx_data    byte presented to the UART; changes only while tx_start is high
//   grant_id   index of the requester currently or last granted
//   busy       high while a word is being granted or serialized
// -----------------------------------------------------------------------------
module tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic [2:0]             grant_id,
  output logic                   busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("tx_arbiter: NUM_REQ must be in 2..8");
  end

`ifdef TX_ARBITER_HEADER_EN
  localparam int IDX_W     = 3;
  localparam int NUM_BYTES = 5;
`else
  localparam int IDX_W     = 2;
  localparam int NUM_BYTES = 4;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [2:0]        last_grant;
  logic [2:0]        winner;
  logic [31:0]       word;
  logic [31:0]       sel_word;
  logic [IDX_W-1:0]  byte_idx;
  logic [7:0]        cur_byte;
  logic [7:0]        tx_data_q;

  // Round-robin pick: offsets are scanned from the farthest down to the
  // nearest so the valid requester closest after last_grant is written last
  // and therefore wins.
  always_comb begin
    winner = last_grant;
    for (int i = NUM_REQ; i >= 1; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_valid[j] && ((int'(last_grant) + i) % NUM_REQ) == j)
          winner = 3'(j);
      end
    end
  end

  // Word of the requester being granted, captured at the end of GRANT.
  always_comb begin
    sel_word = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_id == 3'(j))
        sel_word = req_data[32*j +: 32];
    end
  end

`ifdef TX_ARBITER_HEADER_EN
  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = {5'b10100, grant_id};
      3'd1:    cur_byte = word[31:24];
      3'd2:    cur_byte = word[23:16];
      3'd3:    cur_byte = word[15:8];
      default: cur_byte = word[7:0];
    endcase
  end
`else
  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = word[31:24];
      2'd1:    cur_byte = word[23:16];
      2'd2:    cur_byte = word[15:8];
      default: cur_byte = word[7:0];
    endcase
  end
`endif

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (|req_valid) state_next = GRANT;
      end
      GRANT: begin
        for (int j = 0; j < NUM_REQ; j++)
          req_ready[j] = (grant_id == 3'(j));
        state_next = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = (byte_idx == LAST_IDX) ? IDLE : SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 3'(NUM_REQ - 1);
      grant_id   <= '0;
      word       <= '0;
      byte_idx   <= '0;
      tx_data_q  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && |req_valid) begin
        grant_id   <= winner;
        last_grant <= winner;
      end
      if (state == GRANT) begin
        word     <= sel_word;
        byte_idx <= '0;
      end
      if (state == WAIT_DONE && !tx_busy)
        byte_idx <= byte_idx + 1'b1;
      if (tx_start)
        tx_data_q <= cur_byte;
    end
  end

  // The new byte is forwarded during the start pulse itself and then held by
  // tx_data_q, so tx_data only ever changes while tx_start is high.
  assign tx_data = tx_start ? cur_byte : tx_data_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_arbiter -- directed self-checking bench for tx_arbiter (NUM_REQ = 4).
// A small UART model raises tx_busy for 10 cycles after each tx_start; an
// extra force_busy input lets a scenario hold the transmitter busy.
// -----------------------------------------------------------------------------
module tb_tx_arbiter;

  localparam int N = 4;
`ifdef TX_ARBITER_HEADER_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int UART_LEN = 10;

  localparam logic [31:0] W0 = 32'h11223344;
  localparam logic [31:0] W1 = 32'hA1B2C3D4;
  localparam logic [31:0] W2 = 32'h55667788;
  localparam logic [31:0] W3 = 32'h99AABBCC;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            tx_busy;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [2:0]      grant_id;
  logic            busy;

  logic            force_busy;
  int              uart_cnt;

  int              tests_run    = 0;
  int              tests_failed = 0;
  int              proto_errs   = 0;

  logic [7:0]      byte_q[$];
  int              grant_q[$];
  int              ready_cnt[N];
  logic            prev_start;

  tx_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // UART model: busy for UART_LEN cycles after each accepted start.
  always @(posedge clk or posedge rst) begin
    if (rst)                uart_cnt <= 0;
    else if (tx_start)      uart_cnt <= UART_LEN;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end
  assign tx_busy = force_busy | (uart_cnt != 0);

  // Observation and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (tx_start) byte_q.push_back(tx_data);
      if (tx_start && prev_start) begin
        proto_errs++;
        $display("FAIL proto_double_start: tx_start high two cycles, got 1/1 required not both");
      end
      if (tx_start && tx_busy) begin
        proto_errs++;
        $display("FAIL proto_start_while_busy: tx_start=1 tx_busy=1, required tx_start=0");
      end
      if (!$onehot0(req_ready)) begin
        proto_errs++;
        $display("FAIL proto_ready_onehot: req_ready=%b, required one-hot or zero", req_ready);
      end
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          ready_cnt[i]++;
          grant_q.push_back(i);
        end
      end
      prev_start = tx_start;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_byte(input int gid, input logic [31:0] w, input int k);
    int kk;
    kk = k;
`ifdef TX_ARBITER_HEADER_EN
    if (kk == 0) return {5'b10100, 3'(gid)};
    kk = kk - 1;
`endif
    case (kk)
      0:       return w[31:24];
      1:       return w[23:16];
      2:       return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    byte_q.delete();
    grant_q.delete();
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    force_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_grants(input int n, input int max_cycles, input string name);
    int c = 0;
    while (grant_q.size() < n && c < max_cycles) begin
      sample_mid();
      c++;
    end
    if (grant_q.size() < n) begin
      tests_run++; tests_failed++;
      $display("FAIL %s: timeout, got %0d grants after %0d cycles, required %0d", name, grant_q.size(), c, n);
    end
  endtask

  task automatic wait_bytes(input int n, input int max_cycles, input string name);
    int c = 0;
    while (byte_q.size() < n && c < max_cycles) begin
      sample_mid();
      c++;
    end
    if (byte_q.size() < n) begin
      tests_run++; tests_failed++;
      $display("FAIL %s: timeout, got %0d bytes after %0d cycles, required %0d", name, byte_q.size(), c, n);
    end
  endtask

  task automatic wait_idle(input int n_bytes, input int max_cycles, input string name);
    int c = 0;
    while (!(byte_q.size() >= n_bytes && busy === 1'b0) && c < max_cycles) begin
      sample_mid();
      c++;
    end
    if (!(byte_q.size() >= n_bytes && busy === 1'b0)) begin
      tests_run++; tests_failed++;
      $display("FAIL %s: timeout, got %0d bytes busy=%b after %0d cycles, required %0d bytes busy=0",
               name, byte_q.size(), busy, c, n_bytes);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '0;
    force_busy = 1'b0;
    req_data   = {W3, W2, W1, W0};
    repeat (2) sample_mid();
    tests_run++; if (tx_start !== 1'b0)  begin tests_failed++; $display("FAIL reset_tx_start: got %b, required 0", tx_start); end
    tests_run++; if (tx_data !== 8'h00)  begin tests_failed++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    tests_run++; if (req_ready !== '0)   begin tests_failed++; $display("FAIL reset_req_ready: got %b, required 0000", req_ready); end
    tests_run++; if (grant_id !== 3'd0)  begin tests_failed++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
    drive_edge();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_single();
    do_reset();
    drive_edge();
    req_valid = 4'b0010;
    wait_grants(1, 10, "single_grant");
    drive_edge();
    req_valid = '0;
    wait_idle(NB, 200, "single_done");
    repeat (3) sample_mid();
    tests_run++; if (ready_cnt[1] !== 1)     begin tests_failed++; $display("FAIL single_ready1: got %0d pulses, required 1", ready_cnt[1]); end
    tests_run++; if (grant_q.size() !== 1)   begin tests_failed++; $display("FAIL single_ready_total: got %0d pulses, required 1", grant_q.size()); end
    tests_run++; if (byte_q.size() !== NB)   begin tests_failed++; $display("FAIL single_byte_count: got %0d, required %0d", byte_q.size(), NB); end
    for (int k = 0; k < NB; k++) begin
      if (k < byte_q.size()) begin
        tests_run++;
        if (byte_q[k] !== exp_byte(1, W1, k)) begin
          tests_failed++;
          $display("FAIL single_byte%0d: got %h, required %h", k, byte_q[k], exp_byte(1, W1, k));
        end
      end
    end
    tests_run++; if (grant_id !== 3'd1) begin tests_failed++; $display("FAIL single_grant_id_idle: got %0d, required 1", grant_id); end
    tests_run++; if (busy !== 1'b0)     begin tests_failed++; $display("FAIL single_busy_idle: got %b, required 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    drive_edge();
    req_valid = 4'b1111;
    wait_grants(5, 400, "rr_grants");
    drive_edge();
    req_valid = '0;
    wait_idle(5 * NB, 400, "rr_done");
    for (int k = 0; k < 5; k++) begin
      if (k < grant_q.size()) begin
        tests_run++;
        if (grant_q[k] !== exp_order[k]) begin
          tests_failed++;
          $display("FAIL rr_order%0d: got %0d, required %0d", k, grant_q[k], exp_order[k]);
        end
      end
    end
    tests_run++; if (ready_cnt[0] !== 2) begin tests_failed++; $display("FAIL rr_ready0: got %0d, required 2", ready_cnt[0]); end
    for (int i = 1; i < N; i++) begin
      tests_run++;
      if (ready_cnt[i] !== 1) begin tests_failed++; $display("FAIL rr_ready%0d: got %0d, required 1", i, ready_cnt[i]); end
    end
    tests_run++; if (byte_q.size() !== 5 * NB) begin tests_failed++; $display("FAIL rr_byte_count: got %0d, required %0d", byte_q.size(), 5 * NB); end
    if (byte_q.size() >= 2 * NB) begin
      tests_run++;
      if (byte_q[2*NB-1] !== 8'hD4) begin tests_failed++; $display("FAIL rr_word1_last: got %h, required d4", byte_q[2*NB-1]); end
    end
  endtask

  task automatic test_busy_entry();
    do_reset();
    drive_edge();
    force_busy = 1'b1;
    req_valid  = 4'b0001;
    wait_grants(1, 10, "busy_grant");
    drive_edge();
    req_valid = '0;
    repeat (18) drive_edge();
    tests_run++; if (byte_q.size() !== 0) begin tests_failed++; $display("FAIL busy_no_start: got %0d starts, required 0", byte_q.size()); end
    tests_run++; if (busy !== 1'b1)       begin tests_failed++; $display("FAIL busy_flag_held: got %b, required 1", busy); end
    force_busy = 1'b0;
    sample_mid();
    tests_run++; if (tx_start !== 1'b1)   begin tests_failed++; $display("FAIL busy_first_free_start: got %b, required 1", tx_start); end
    wait_idle(NB, 200, "busy_done");
    tests_run++; if (byte_q.size() !== NB) begin tests_failed++; $display("FAIL busy_byte_count: got %0d, required %0d", byte_q.size(), NB); end
    if (byte_q.size() > 0) begin
      tests_run++;
      if (byte_q[0] !== exp_byte(0, W0, 0)) begin tests_failed++; $display("FAIL busy_first_byte: got %h, required %h", byte_q[0], exp_byte(0, W0, 0)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_edge();
    req_valid = 4'b0100;
    wait_bytes(2, 200, "mid_two_starts");
    rst       = 1'b1;
    req_valid = 4'b1001;
    #1;
    tests_run++; if (tx_start !== 1'b0)  begin tests_failed++; $display("FAIL mid_tx_start: got %b, required 0", tx_start); end
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL mid_busy: got %b, required 0", busy); end
    tests_run++; if (req_ready !== '0)   begin tests_failed++; $display("FAIL mid_req_ready: got %b, required 0000", req_ready); end
    tests_run++; if (tx_data !== 8'h00)  begin tests_failed++; $display("FAIL mid_tx_data: got %h, required 00", tx_data); end
    tests_run++; if (grant_id !== 3'd0)  begin tests_failed++; $display("FAIL mid_grant_id: got %0d, required 0", grant_id); end
    repeat (3) drive_edge();
    tests_run++; if (byte_q.size() !== 2) begin tests_failed++; $display("FAIL mid_no_more_starts: got %0d bytes, required 2", byte_q.size()); end
    rst = 1'b0;
    wait_grants(2, 10, "mid_regrant");
    if (grant_q.size() >= 2) begin
      tests_run++;
      if (grant_q[1] !== 0) begin tests_failed++; $display("FAIL mid_first_after_reset: got %0d, required 0", grant_q[1]); end
    end
    drive_edge();
    req_valid = '0;
    wait_idle(2 + NB, 200, "mid_done");
    tests_run++; if (ready_cnt[2] !== 1) begin tests_failed++; $display("FAIL mid_no_regrant2: got %0d, required 1", ready_cnt[2]); end
    tests_run++; if (ready_cnt[3] !== 0) begin tests_failed++; $display("FAIL mid_ready3: got %0d, required 0", ready_cnt[3]); end
  endtask

  task automatic test_dropped();
    do_reset();
    drive_edge();
    req_valid = 4'b0001;
    wait_grants(1, 10, "drop_grant");
    drive_edge();
    req_valid = '0;
    repeat (5) drive_edge();
    req_valid = 4'b0100;
    drive_edge();
    req_valid = '0;
    wait_idle(NB, 200, "drop_done");
    repeat (5) sample_mid();
    tests_run++; if (ready_cnt[2] !== 0)   begin tests_failed++; $display("FAIL drop_ready2: got %0d, required 0", ready_cnt[2]); end
    tests_run++; if (ready_cnt[0] !== 1)   begin tests_failed++; $display("FAIL drop_ready0: got %0d, required 1", ready_cnt[0]); end
    tests_run++; if (grant_q.size() !== 1) begin tests_failed++; $display("FAIL drop_total_grants: got %0d, required 1", grant_q.size()); end
  endtask

  task automatic test_protocol();
    tests_run++;
    if (proto_errs !== 0) begin
      tests_failed++;
      $display("FAIL protocol_violations: got %0d, required 0", proto_errs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_entry();
    test_reset_mid();
    test_dropped();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
